// File: rtl/dados.sv
// Processor data memory: DEPTH x DATA_W words, synchronous write, registered read,
// synchronous clear on reset. Define DADOS_BYPASS_EN for write-first forwarding.
module dados #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic [ADDR_W-1:0] label,
  output logic [DATA_W-1:0] escrever,
  input  logic [DATA_W-1:0] dado_escrito,
  input  logic              clk,
  input  logic              reset,
  input  logic              ler_memo,
  input  logic              escr_memo
);

  logic [DATA_W-1:0] mem_reg [DEPTH];

  // Each word owns its own clear and write-enable so the whole array can be
  // zeroed in a single reset edge.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_word
      always_ff @(posedge clk) begin
        if (reset) begin
          mem_reg[gi] <= '0;
        end else if (escr_memo && (label == ADDR_W'(gi))) begin
          mem_reg[gi] <= dado_escrito;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      escrever <= '0;
    end else if (ler_memo) begin
`ifdef DADOS_BYPASS_EN
      // Same label is implicit: read and write share one address port.
      if (escr_memo) begin
        escrever <= dado_escrito;
      end else begin
        escrever <= mem_reg[label];
      end
`else
      escrever <= mem_reg[label];
`endif
    end
  end

endmodule

// File: tb/tb_dados.sv
// Directed self-checking bench for dados: reset, write/read, hold,
// same-address read+write, address extremes and mid-operation reset.
module tb_dados;

  logic [7:0] label;
  logic [7:0] escrever;
  logic [7:0] dado_escrito;
  logic       clk;
  logic       reset;
  logic       ler_memo;
  logic       escr_memo;

  int passed = 0;
  int total  = 0;

  dados dut (
    .label        (label),
    .escrever     (escrever),
    .dado_escrito (dado_escrito),
    .clk          (clk),
    .reset        (reset),
    .ler_memo     (ler_memo),
    .escr_memo    (escr_memo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    logic [7:0] same_addr_exp;
`ifdef DADOS_BYPASS_EN
    same_addr_exp = 8'h09;
`else
    same_addr_exp = 8'h05;
`endif

    // Reset with a write attempt held active
    reset = 1'b1; escr_memo = 1'b1; ler_memo = 1'b0; label = 8'h00; dado_escrito = 8'h00;
    repeat (3) tick();
    check("reset_out", escrever, 8'h00);

    reset = 1'b0; escr_memo = 1'b0; ler_memo = 1'b1; label = 8'h00;
    tick();
    check("read_addr0_after_reset", escrever, 8'h00);

    // Write then read
    escr_memo = 1'b1; ler_memo = 1'b0; label = 8'h07; dado_escrito = 8'h05;
    tick();
    check("no_read_while_write_only", escrever, 8'h00);
    escr_memo = 1'b0; ler_memo = 1'b1;
    tick();
    check("read_addr7", escrever, 8'h05);

    // Hold
    ler_memo = 1'b0; label = 8'h00; dado_escrito = 8'h77;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("hold_%0d", i), escrever, 8'h05);
    end

    // Same-address read+write
    ler_memo = 1'b1; escr_memo = 1'b1; label = 8'h07; dado_escrito = 8'h09;
    tick();
    check("same_addr_rw", escrever, same_addr_exp);
    escr_memo = 1'b0;
    tick();
    check("reread_addr7", escrever, 8'h09);

    // Address extremes and aliasing on the top bit
    ler_memo = 1'b0; escr_memo = 1'b1;
    label = 8'h00; dado_escrito = 8'hA5; tick();
    label = 8'hFF; dado_escrito = 8'h5A; tick();
    label = 8'h80; dado_escrito = 8'h3C; tick();
    escr_memo = 1'b0; ler_memo = 1'b1;
    label = 8'h00; tick();
    check("read_addr0", escrever, 8'hA5);
    label = 8'hFF; tick();
    check("read_addr255", escrever, 8'h5A);
    label = 8'h80; tick();
    check("read_addr128", escrever, 8'h3C);
    label = 8'h7F; tick();
    check("read_addr127_untouched", escrever, 8'h00);

    // Reset mid-operation
    label = 8'h07; tick();
    check("pre_reset_addr7", escrever, 8'h09);
    reset = 1'b1; escr_memo = 1'b1; dado_escrito = 8'h03;
    tick();
    check("mid_reset_out", escrever, 8'h00);
    reset = 1'b0; escr_memo = 1'b0; ler_memo = 1'b1; label = 8'h05;
    tick();
    label = 8'h07; tick();
    check("post_reset_addr7", escrever, 8'h00);
    label = 8'hFF; tick();
    check("post_reset_addr255", escrever, 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
